// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states, function-unit
// and shifter codes, flag positions and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_MOV = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_NOT = 4'h7,
    OP_ADI = 4'h8,
    OP_LD  = 4'h9,
    OP_ST  = 4'hA,
    OP_SHL = 4'hB,
    OP_SHR = 4'hC,
    OP_BRZ = 4'hD,
    OP_JMP = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [3:0] G_PASS_A = 4'b0000;
  localparam logic [3:0] G_ADD    = 4'b0010;
  localparam logic [3:0] G_SUB    = 4'b0101;
  localparam logic [3:0] G_AND    = 4'b1000;
  localparam logic [3:0] G_OR     = 4'b1010;
  localparam logic [3:0] G_XOR    = 4'b1100;
  localparam logic [3:0] G_NOT    = 4'b1110;

  localparam logic [1:0] H_PASS = 2'b00;
  localparam logic [1:0] H_SHR  = 2'b01;
  localparam logic [1:0] H_SHL  = 2'b10;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int DR_MSB  = 11;
  localparam int DR_LSB  = 10;
  localparam int SA_MSB  = 9;
  localparam int SA_LSB  = 8;
  localparam int SB_MSB  = 7;
  localparam int SB_LSB  = 6;
  localparam int TGT_MSB = 7;
  localparam int TGT_LSB = 0;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/decodificador_instr.sv
// Combinational instruction decoder: IR to datapath control-word fields plus
// the qualifiers the sequencer uses to gate strobes, flags and branches.
module decodificador_instr
  import cpu_pkg::*;
#(
  parameter int m = 4
) (
  input  logic [15:0]  ir,
  output logic [1:0]   sel_a,
  output logic [1:0]   sel_b,
  output logic [1:0]   sel_d,
  output logic [1:0]   sel_h,
  output logic [3:0]   sel_g,
  output logic         sel_mb,
  output logic         sel_md,
  output logic         sel_mf,
  output logic [m-1:0] constant,
  output logic [7:0]   target,
  output logic         writes_reg,
  output logic         writes_mem,
  output logic         updates_flags,
  output logic         is_brz,
  output logic         is_jmp,
  output logic         is_hlt
);

  opcode_t    op;
  logic [1:0] dr, sa, sb;

  assign op       = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign dr       = ir[DR_MSB:DR_LSB];
  assign sa       = ir[SA_MSB:SA_LSB];
  assign sb       = ir[SB_MSB:SB_LSB];
  assign constant = ir[m-1:0];
  assign target   = ir[TGT_MSB:TGT_LSB];

  always_comb begin
    sel_a         = '0;
    sel_b         = '0;
    sel_d         = '0;
    sel_h         = H_PASS;
    sel_g         = G_PASS_A;
    sel_mb        = 1'b0;
    sel_md        = 1'b0;
    sel_mf        = 1'b0;
    writes_reg    = 1'b0;
    writes_mem    = 1'b0;
    updates_flags = 1'b0;
    is_brz        = 1'b0;
    is_jmp        = 1'b0;
    is_hlt        = 1'b0;
    unique case (op)
      OP_NOP: ;
      OP_MOV: begin
        sel_a = sa; sel_d = dr; sel_g = G_PASS_A;
        writes_reg = 1'b1; updates_flags = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        sel_a = sa; sel_b = sb; sel_d = dr;
        writes_reg = 1'b1; updates_flags = 1'b1;
        unique case (op)
          OP_ADD:  sel_g = G_ADD;
          OP_SUB:  sel_g = G_SUB;
          OP_AND:  sel_g = G_AND;
          OP_OR:   sel_g = G_OR;
          default: sel_g = G_XOR;
        endcase
      end
      OP_NOT: begin
        sel_a = sa; sel_d = dr; sel_g = G_NOT;
        writes_reg = 1'b1; updates_flags = 1'b1;
      end
      OP_ADI: begin
        sel_a = sa; sel_d = dr; sel_g = G_ADD; sel_mb = 1'b1;
        writes_reg = 1'b1; updates_flags = 1'b1;
      end
      OP_LD: begin
        sel_a = sa; sel_d = dr; sel_md = 1'b1;
        writes_reg = 1'b1;
      end
      OP_ST: begin
        sel_a = sa; sel_b = sb;
        writes_mem = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        sel_b = sb; sel_d = dr; sel_mf = 1'b1;
        sel_h = (op == OP_SHL) ? H_SHL : H_SHR;
        writes_reg = 1'b1; updates_flags = 1'b1;
      end
      OP_BRZ: is_brz = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      OP_HLT: is_hlt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/unidad_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE sequencer with PC, IR and a
// latched flag register, driving the Procesador datapath control word.
module unidad_control
  import cpu_pkg::*;
#(
  parameter int m    = 4,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  input  logic [3:0]      Banderas,
  output logic [1:0]      Select_A,
  output logic [1:0]      Select_B,
  output logic [1:0]      Select_D,
  output logic [1:0]      Select_H,
  output logic [m-1:0]    Constant_in,
  output logic [3:0]      Select_G,
  output logic            Select_MB,
  output logic            Select_MD,
  output logic            Select_MF,
  output logic [3:0]      Enable_load,
  output logic            mem_we,
  output logic            halted
);

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [3:0]      flags_q;

  logic [7:0] target;
  logic       writes_reg, writes_mem, updates_flags;
  logic       is_brz, is_jmp, is_hlt;
  logic       in_execute;
  logic       take_branch;

  decodificador_instr #(.m(m)) u_dec (
    .ir            (ir_q),
    .sel_a         (Select_A),
    .sel_b         (Select_B),
    .sel_d         (Select_D),
    .sel_h         (Select_H),
    .sel_g         (Select_G),
    .sel_mb        (Select_MB),
    .sel_md        (Select_MD),
    .sel_mf        (Select_MF),
    .constant      (Constant_in),
    .target        (target),
    .writes_reg    (writes_reg),
    .writes_mem    (writes_mem),
    .updates_flags (updates_flags),
    .is_brz        (is_brz),
    .is_jmp        (is_jmp),
    .is_hlt        (is_hlt)
  );

  assign in_execute  = (state == EXECUTE);
  assign take_branch = is_jmp || (is_brz && flags_q[FLAG_Z]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          ir_q  <= instr_data;
          pc_q  <= pc_q + 1'b1;
          state <= DECODE;
        end
        DECODE: begin
          state <= is_hlt ? HALT : EXECUTE;
        end
        EXECUTE: begin
          if (updates_flags) flags_q <= Banderas;
          // Target is 8 bits wide; the cast truncates or zero-extends to PC_W.
          if (take_branch) pc_q <= PC_W'(target);
          state <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes derive from the async-reset state, so they drop as soon as reset asserts.
  assign Enable_load = (in_execute && writes_reg) ? onehot4(Select_D) : 4'b0000;
  assign mem_we      = in_execute && writes_mem;
  assign halted      = (state == HALT);
  assign instr_addr  = pc_q;

  // V, C and N are latched for completeness but no instruction consumes them yet.
  logic flags_unused;
  assign flags_unused = ^{flags_q[FLAG_V], flags_q[FLAG_C], flags_q[FLAG_N]};

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: directed steps plus random instruction streams,
// checked against an instruction-level reference model.
module tb_unidad_control;

  localparam int M   = 4;
  localparam int PCW = 8;

  // Opcode property sets, bit i set when opcode i has the property.
  localparam logic [15:0] USES_A   = 16'h07FE;
  localparam logic [15:0] USES_B   = 16'h1C7C;
  localparam logic [15:0] WRITES_D = 16'h1BFE;
  localparam logic [15:0] SETS_FLG = 16'h19FE;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] d;
    logic [1:0] h;
    logic [3:0] g;
    logic       mb;
    logic       md;
    logic       mf;
    logic [3:0] k;
    logic [3:0] el;
    logic       we;
  } ctl_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [PCW-1:0] instr_addr;
  logic [15:0]    instr_data;
  logic [3:0]     Banderas = 4'b0000;
  logic [1:0]     Select_A, Select_B, Select_D, Select_H;
  logic [M-1:0]   Constant_in;
  logic [3:0]     Select_G;
  logic           Select_MB, Select_MD, Select_MF;
  logic [3:0]     Enable_load;
  logic           mem_we;
  logic           halted;

  logic [15:0] imem [256];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_pc = 8'h00;
  logic [3:0]  model_flags = 4'h0;

  assign instr_data = imem[instr_addr];

  always #5 clk = ~clk;

  unidad_control #(.m(M), .PC_W(PCW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_addr  (instr_addr),
    .instr_data  (instr_data),
    .Banderas    (Banderas),
    .Select_A    (Select_A),
    .Select_B    (Select_B),
    .Select_D    (Select_D),
    .Select_H    (Select_H),
    .Constant_in (Constant_in),
    .Select_G    (Select_G),
    .Select_MB   (Select_MB),
    .Select_MD   (Select_MD),
    .Select_MF   (Select_MF),
    .Enable_load (Enable_load),
    .mem_we      (mem_we),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control word an instruction should produce; strobes only when executing.
  function automatic ctl_t expect_ctl(input logic [15:0] ins, input logic executing);
    ctl_t c;
    int   op;
    op   = int'(ins[15:12]);
    c    = '0;
    c.k  = ins[3:0];
    if (USES_A[op]) c.a = ins[9:8];
    if (USES_B[op]) c.b = ins[7:6];
    if (WRITES_D[op]) begin
      c.d = ins[11:10];
      if (executing) c.el = 4'(1 << ins[11:10]);
    end
    case (op)
      2, 8: c.g = 4'b0010;
      3:    c.g = 4'b0101;
      4:    c.g = 4'b1000;
      5:    c.g = 4'b1010;
      6:    c.g = 4'b1100;
      7:    c.g = 4'b1110;
      default: c.g = 4'b0000;
    endcase
    c.mb = (op == 8);
    c.md = (op == 9);
    c.mf = (op == 11) || (op == 12);
    c.h  = (op == 11) ? 2'b10 : (op == 12) ? 2'b01 : 2'b00;
    c.we = executing && (op == 10);
    return c;
  endfunction

  task automatic check_ctl(input string ph, input ctl_t e);
    check({ph, "_sel_a"}, 32'(Select_A), 32'(e.a));
    check({ph, "_sel_b"}, 32'(Select_B), 32'(e.b));
    check({ph, "_sel_d"}, 32'(Select_D), 32'(e.d));
    check({ph, "_sel_h"}, 32'(Select_H), 32'(e.h));
    check({ph, "_sel_g"}, 32'(Select_G), 32'(e.g));
    check({ph, "_mb"}, 32'(Select_MB), 32'(e.mb));
    check({ph, "_md"}, 32'(Select_MD), 32'(e.md));
    check({ph, "_mf"}, 32'(Select_MF), 32'(e.mf));
    check({ph, "_const"}, 32'(Constant_in), 32'(e.k));
    check({ph, "_enable_load"}, 32'(Enable_load), 32'(e.el));
    check({ph, "_mem_we"}, 32'(mem_we), 32'(e.we));
    check({ph, "_halted"}, 32'(halted), 32'd0);
  endtask

  // Entered #1 after the edge that starts FETCH; leaves at the next FETCH.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic [3:0] fl);
    int op;
    op = int'(ins[15:12]);
    imem[model_pc] = ins;
    #0;
    check({tag, "_fetch_addr"}, 32'(instr_addr), 32'(model_pc));
    check({tag, "_fetch_el"}, 32'(Enable_load), 32'd0);
    check({tag, "_fetch_we"}, 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    check_ctl({tag, "_decode"}, expect_ctl(ins, 1'b0));
    model_pc = model_pc + 8'd1;
    Banderas = fl;
    @(posedge clk); #1;
    if (op == 15) begin
      check({tag, "_halted"}, 32'(halted), 32'd1);
      check({tag, "_halt_addr"}, 32'(instr_addr), 32'(model_pc));
    end else begin
      check_ctl({tag, "_exec"}, expect_ctl(ins, 1'b1));
      if (SETS_FLG[op]) model_flags = fl;
      if (op == 14 || (op == 13 && model_flags[0])) model_pc = ins[7:0];
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] ins;
    logic [31:0] r;
    logic [3:0]  op;
    logic [7:0]  frozen;

    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;

    // Reset state
    #12;
    check("rst_addr", 32'(instr_addr), 32'h00);
    check("rst_el", 32'(Enable_load), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_selects", 32'({Select_A, Select_B, Select_D, Select_H, Select_G,
                              Select_MB, Select_MD, Select_MF, Constant_in}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed program
    run_instr("add", 16'h26C0, 4'b0000);
    check("add_next_addr", 32'(instr_addr), 32'h01);
    run_instr("adi", 16'h8105, 4'b0010);
    run_instr("sub_z1", 16'h3000, 4'b0001);
    run_instr("brz_taken", 16'hD020, 4'b0000);
    check("brz_taken_addr", 32'(instr_addr), 32'h20);
    run_instr("sub_z0", 16'h3000, 4'b0000);
    run_instr("brz_not", 16'hD020, 4'b0001);
    check("brz_not_addr", 32'(instr_addr), 32'h22);
    run_instr("st", 16'hA0C0, 4'b1111);
    run_instr("jmp_ff", 16'hE0FF, 4'b0000);
    check("jmp_addr", 32'(instr_addr), 32'hFF);
    run_instr("nop_ff", 16'h0000, 4'b0000);
    check("wrap_addr", 32'(instr_addr), 32'h00);

    // Random instruction stream (no HLT)
    for (int n = 0; n < 60; n++) begin
      r   = $urandom;
      op  = 4'($urandom_range(0, 14));
      ins = {op, r[11:0]};
      run_instr("rnd", ins, 4'($urandom_range(0, 15)));
    end

    // Leave Z set so the reset test can see flags cleared
    run_instr("sub_pre_hlt", 16'h3000, 4'b0001);
    run_instr("hlt", 16'hF000, 4'b0000);
    frozen = model_pc;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check("hlt_frozen_addr", 32'(instr_addr), 32'(frozen));
      check("hlt_el", 32'(Enable_load), 32'h0);
      check("hlt_we", 32'(mem_we), 32'h0);
      check("hlt_still_halted", 32'(halted), 32'h1);
    end
    rst_n = 1'b0;
    #1;
    check("hlt_rst_addr", 32'(instr_addr), 32'h00);
    check("hlt_rst_halted", 32'(halted), 32'h0);

    // Reset asserted mid-EXECUTE
    imem[0] = 16'h26C0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midexec_el_before", 32'(Enable_load), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("midexec_el_drop", 32'(Enable_load), 32'h0);
    check("midexec_we_drop", 32'(mem_we), 32'h0);
    check("midexec_addr", 32'(instr_addr), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_pc    = 8'h00;
    model_flags = 4'h0;

    // Flags cleared by reset: BRZ must fall through
    run_instr("brz_after_rst", 16'hD020, 4'b0001);
    check("brz_after_rst_addr", 32'(instr_addr), 32'h01);
    run_instr("st_after_rst", 16'hA0C0, 4'b0000);
    run_instr("shl", 16'hB4C0, 4'b0100);
    run_instr("shr", 16'hC880, 4'b0010);
    run_instr("ld", 16'h9D00, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
